// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one shared (WIDTH+1)-bit adder, fixed
// latency of WIDTH iterations plus a one-cycle done pulse for every operation.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    // state | meaning
    // IDLE  | waiting for start; operands sampled on the accepting edge
    // CALC  | one shift/add or shift/subtract iteration per edge
    // DONE  | result valid, done pulse; always returns to IDLE
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [2:0]       op;
    logic             sa, sb, dz, ovf;
    logic [WIDTH-1:0] opnd, hi, lo;

    // operand decode for the accepting edge
    logic             a_signed, b_signed, in_sa, in_sb, in_mul, in_dz, in_ovf;
    logic [WIDTH-1:0] mag_a_in, mag_b_in;

    always_comb begin
        a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        in_sa    = a_signed & srcA[WIDTH-1];
        in_sb    = b_signed & srcB[WIDTH-1];
        mag_a_in = in_sa ? -srcA : srcA;
        mag_b_in = in_sb ? -srcB : srcB;
        in_mul   = ~funct3[2];
        in_dz    = (srcB == '0);
        in_ovf   = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                   (srcA == MOST_NEG) && (srcB == '1);
    end

    // Shared adder: multiply adds the multiplicand when the multiplier LSB is
    // set; divide subtracts the divisor from the shifted partial remainder.
    logic             is_mul, qbit;
    logic [WIDTH:0]   add_a, add_b;
    logic [WIDTH+1:0] sum;
    logic [WIDTH-1:0] nxt_hi, nxt_lo;

    always_comb begin
        is_mul = ~op[2];
        add_a  = is_mul ? {1'b0, hi} : {hi, lo[WIDTH-1]};
        add_b  = is_mul ? (lo[0] ? {1'b0, opnd} : '0) : ~{1'b0, opnd};
        sum    = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, ~is_mul};
        qbit   = sum[WIDTH+1];
        if (is_mul) begin
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], lo[WIDTH-1:1]};
        end else begin
            nxt_hi = qbit ? sum[WIDTH-1:0] : add_a[WIDTH-1:0];
            nxt_lo = {lo[WIDTH-2:0], qbit};
        end
    end

    logic [2*WIDTH-1:0] prod, prod_c;
    logic [WIDTH-1:0]   quo_c, rem_c, fin;

    always_comb begin
        prod   = {nxt_hi, nxt_lo};
        prod_c = (sa ^ sb) ? -prod : prod;
        quo_c  = (sa ^ sb) ? -nxt_lo : nxt_lo;
        rem_c  = sa ? -nxt_hi : nxt_hi;
        fin    = '0;
        case (op)
            3'b000:                 fin = prod_c[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fin = prod_c[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fin = dz ? '1 : (ovf ? MOST_NEG : quo_c);
            // with a zero divisor the restored remainder is the dividend itself
            default:                fin = ovf ? '0 : rem_c;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            op     <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            dz     <= 1'b0;
            ovf    <= 1'b0;
            opnd   <= '0;
            hi     <= '0;
            lo     <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op    <= funct3;
                        sa    <= in_sa;
                        sb    <= in_sb;
                        dz    <= in_dz;
                        ovf   <= in_ovf;
                        opnd  <= in_mul ? mag_a_in : mag_b_in;
                        hi    <= '0;
                        lo    <= in_mul ? mag_b_in : mag_a_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    hi  <= nxt_hi;
                    lo  <= nxt_lo;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH-1)) begin
                        result <= fin;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
